// File: rtl/pds_pkg.sv
// Shared types and widths for the PDS port power sequencer.
// Provides the sequencer state enum and per-port field widths.
package pds_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RAMP,
        SEQ_SHED
    } seq_state_t;

    localparam int PRIO_W = 2;
    localparam int PREQ_W = 4;

endpackage

// File: rtl/pds_prio_pick.sv
// Priority picker over a port mask.
// MAX_NOT_MIN=1: highest prio, lowest index. MAX_NOT_MIN=0: lowest prio, highest index.
// Ports: mask (candidates), prio (PRIO_W bits per port), valid, idx.
module pds_prio_pick
    import pds_pkg::*;
#(
    parameter int numPorts    = 4,
    parameter bit MAX_NOT_MIN = 1'b1
) (
    input  logic [numPorts-1:0]        mask,
    input  logic [PRIO_W*numPorts-1:0] prio,
    output logic                       valid,
    output logic [3:0]                 idx
);

    logic [PRIO_W-1:0] best;
    logic [PRIO_W-1:0] p;

    // Scanning upward: strict > keeps the first (lowest) index on ties,
    // <= lets the last (highest) index win ties.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        best  = '0;
        p     = '0;
        for (int i = 0; i < numPorts; i++) begin
            if (mask[i]) begin
                p = prio[PRIO_W*i +: PRIO_W];
                if (!valid || (MAX_NOT_MIN ? (p > best) : (p <= best))) begin
                    valid = 1'b1;
                    idx   = 4'(i);
                    best  = p;
                end
            end
        end
    end

endmodule

// File: rtl/pds_port_sequencer.sv
// Power-up scheduler: grants ports one at a time by priority within budget,
// spaces grants by RAMP_CYCLES, drops lost/forced-off ports, sheds on overdraw.
// Ports: clk, rst_n (sync, active-low), det, off, prio, pwr_req, pwr_bdj,
//        ports_off -> on, pwr_used, grant, grant_idx, busy
//        [+ shed_cnt when PDS_SEQ_SHED_CNT_EN is defined].
module pds_port_sequencer
    import pds_pkg::*;
#(
    parameter int numPorts    = 4,
    parameter int RAMP_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [numPorts-1:0]        det,
    input  logic [numPorts-1:0]        off,
    input  logic [PRIO_W*numPorts-1:0] prio,
    input  logic [PREQ_W*numPorts-1:0] pwr_req,
    input  logic [7:0]                 pwr_bdj,
    input  logic                       ports_off,
    output logic [numPorts-1:0]        on,
    output logic [7:0]                 pwr_used,
    output logic                       grant,
    output logic [3:0]                 grant_idx,
    output logic                       busy
`ifdef PDS_SEQ_SHED_CNT_EN
    ,
    output logic [7:0]                 shed_cnt
`endif
);

    localparam int CNT_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RAMP_LOAD = CNT_W'(RAMP_CYCLES - 1);

    seq_state_t           state;
    logic [CNT_W-1:0]     ramp_cnt;
    logic                 over;
    logic [numPorts-1:0]  drop_mask;
    logic [numPorts-1:0]  elig;
    logic [numPorts-1:0]  grant_set;
    logic [numPorts-1:0]  shed_clr;
    logic                 g_vld;
    logic [3:0]           g_idx;
    logic                 s_vld;
    logic [3:0]           s_idx;
    logic                 do_grant;
    logic                 do_shed;

    always_comb begin
        pwr_used = '0;
        for (int i = 0; i < numPorts; i++) begin
            if (on[i]) begin
                pwr_used = pwr_used + 8'(pwr_req[PREQ_W*i +: PREQ_W]);
            end
        end
    end

    // Fit test done in 9 bits so a near-full budget never wraps.
    always_comb begin
        elig = '0;
        for (int i = 0; i < numPorts; i++) begin
            elig[i] = det[i] & ~off[i] & ~on[i]
                    & (({1'b0, pwr_used} + 9'(pwr_req[PREQ_W*i +: PREQ_W]))
                       <= {1'b0, pwr_bdj});
        end
    end

    assign over      = pwr_used > pwr_bdj;
    assign drop_mask = on & (~det | off);

    pds_prio_pick #(
        .numPorts    (numPorts),
        .MAX_NOT_MIN (1'b1)
    ) u_grant_pick (
        .mask  (elig),
        .prio  (prio),
        .valid (g_vld),
        .idx   (g_idx)
    );

    // Ports already leaving via drop are not counted as shed victims.
    pds_prio_pick #(
        .numPorts    (numPorts),
        .MAX_NOT_MIN (1'b0)
    ) u_shed_pick (
        .mask  (on & ~drop_mask),
        .prio  (prio),
        .valid (s_vld),
        .idx   (s_idx)
    );

    assign do_grant  = (state == SEQ_IDLE) && !over && g_vld;
    assign do_shed   = (state == SEQ_SHED) && over && s_vld;
    assign grant_set = do_grant ? (numPorts'(1) << g_idx) : '0;
    assign shed_clr  = do_shed ? (numPorts'(1) << s_idx) : '0;
    assign busy      = (state != SEQ_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            on        <= '0;
            grant     <= 1'b0;
            grant_idx <= '0;
            state     <= SEQ_IDLE;
            ramp_cnt  <= '0;
        end else if (ports_off) begin
            on       <= '0;
            grant    <= 1'b0;
            state    <= SEQ_IDLE;
            ramp_cnt <= '0;
        end else begin
            on    <= (on & ~drop_mask & ~shed_clr) | grant_set;
            grant <= do_grant;
            if (do_grant) begin
                grant_idx <= g_idx;
            end
            unique case (state)
                SEQ_IDLE: begin
                    if (over) begin
                        state <= SEQ_SHED;
                    end else if (g_vld) begin
                        state    <= SEQ_RAMP;
                        ramp_cnt <= RAMP_LOAD;
                    end
                end
                SEQ_RAMP: begin
                    if (over) begin
                        state <= SEQ_SHED;
                    end else if (ramp_cnt == '0) begin
                        state <= SEQ_IDLE;
                    end else begin
                        ramp_cnt <= ramp_cnt - 1'b1;
                    end
                end
                SEQ_SHED: begin
                    if (!over) begin
                        state <= SEQ_IDLE;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

`ifdef PDS_SEQ_SHED_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shed_cnt <= '0;
        end else if (!ports_off && do_shed && shed_cnt != 8'hFF) begin
            shed_cnt <= shed_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pds_port_sequencer.sv
// Self-checking bench for pds_port_sequencer: directed scenarios plus
// random traffic checked against a cycle-level behavioural model.
module tb_pds_port_sequencer;

    localparam int N = 4;
    localparam int R = 8;
    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_SHED = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  det;
    logic [3:0]  off;
    logic [7:0]  prio;
    logic [15:0] pwr_req;
    logic [7:0]  pwr_bdj;
    logic        ports_off;
    logic [3:0]  on;
    logic [7:0]  pwr_used;
    logic        grant;
    logic [3:0]  grant_idx;
    logic        busy;
`ifdef PDS_SEQ_SHED_CNT_EN
    logic [7:0]  shed_cnt;
`endif

    pds_port_sequencer #(.numPorts(N), .RAMP_CYCLES(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .det       (det),
        .off       (off),
        .prio      (prio),
        .pwr_req   (pwr_req),
        .pwr_bdj   (pwr_bdj),
        .ports_off (ports_off),
        .on        (on),
        .pwr_used  (pwr_used),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef PDS_SEQ_SHED_CNT_EN
        ,
        .shed_cnt  (shed_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit [3:0] m_on;
    bit       m_grant;
    int       m_gidx;
    int       m_mode;
    int       m_ramp;
    int       m_shed;
    int       cyc = 0;
    int       gq[$];
    int       gc[$];

    function automatic int m_used();
        int s = 0;
        for (int i = 0; i < N; i++)
            if (m_on[i]) s += int'(pwr_req[4*i +: 4]);
        return s;
    endfunction

    // Score = prio*16 + (15-index): max gives highest prio/lowest index,
    // min gives lowest prio/highest index.
    function automatic int pick(bit [3:0] mask, bit want_max);
        int best = -1;
        int bs = 0;
        int sc;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                sc = int'(prio[2*i +: 2]) * 16 + (15 - i);
                if (best < 0 || (want_max ? sc > bs : sc < bs)) begin
                    best = i;
                    bs = sc;
                end
            end
        end
        return best;
    endfunction

    task automatic model_edge();
        int used;
        int g;
        int v;
        bit [3:0] drop;
        bit [3:0] elig;
        if (!rst_n) begin
            m_on = '0; m_grant = 0; m_gidx = 0;
            m_mode = M_IDLE; m_ramp = 0; m_shed = 0;
            return;
        end
        if (ports_off) begin
            m_on = '0; m_grant = 0; m_mode = M_IDLE; m_ramp = 0;
            return;
        end
        used = m_used();
        drop = m_on & (~det | off);
        m_grant = 0;
        for (int i = 0; i < N; i++)
            elig[i] = det[i] && !off[i] && !m_on[i]
                   && (used + int'(pwr_req[4*i +: 4]) <= int'(pwr_bdj));
        case (m_mode)
            M_IDLE: begin
                if (used > int'(pwr_bdj)) m_mode = M_SHED;
                else begin
                    g = pick(elig, 1'b1);
                    if (g >= 0) begin
                        m_on[g] = 1'b1; m_grant = 1; m_gidx = g;
                        m_ramp = R - 1; m_mode = M_RAMP;
                    end
                end
            end
            M_RAMP: begin
                if (used > int'(pwr_bdj)) m_mode = M_SHED;
                else if (m_ramp == 0) m_mode = M_IDLE;
                else m_ramp--;
            end
            default: begin
                if (used <= int'(pwr_bdj)) m_mode = M_IDLE;
                else begin
                    v = pick(m_on & ~drop, 1'b0);
                    if (v >= 0) begin
                        m_on[v] = 1'b0;
                        if (m_shed < 255) m_shed++;
                    end
                end
            end
        endcase
        m_on = m_on & ~drop;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (grant === 1'b1) begin
            gq.push_back(int'(grant_idx));
            gc.push_back(cyc);
        end
        chk("on", 32'(on), 32'(m_on));
        chk("pwr_used", 32'(pwr_used), 32'(m_used()));
        chk("grant", 32'(grant), 32'(m_grant));
        chk("grant_idx", 32'(grant_idx), 32'(m_gidx));
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
`ifdef PDS_SEQ_SHED_CNT_EN
        chk("shed_cnt", 32'(shed_cnt), 32'(m_shed));
`endif
    endtask

    initial begin
        rst_n = 0; det = '0; off = '0; prio = '0;
        pwr_req = 16'h4444; pwr_bdj = 8'd100; ports_off = 0;
        step();
        step();
        chk("rst_on", 32'(on), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1;
        step();

        // Grant order and spacing
        prio = 8'b01_11_01_01;
        det = 4'b1111;
        gq.delete(); gc.delete();
        repeat (40) step();
        chk("t1_ngrants", 32'(gq.size()), 32'd4);
        if (gq.size() == 4) begin
            chk("t1_g0", 32'(gq[0]), 32'd2);
            chk("t1_g1", 32'(gq[1]), 32'd0);
            chk("t1_g2", 32'(gq[2]), 32'd1);
            chk("t1_g3", 32'(gq[3]), 32'd3);
            for (int k = 1; k < 4; k++)
                chk("t1_space", 32'(gc[k] - gc[k-1]), 32'd9);
        end
        chk("t1_on", 32'(on), 32'hF);
        chk("t1_used", 32'(pwr_used), 32'd16);

        // Shed on budget drop
        prio = 8'b11_10_01_00;
        pwr_bdj = 8'd9;
        step();
        step();
        chk("t2_first", 32'(on), 32'hE);
        step();
        chk("t2_second", 32'(on), 32'hC);
        repeat (3) step();
        chk("t2_on", 32'(on), 32'hC);
`ifdef PDS_SEQ_SHED_CNT_EN
        chk("t2_shed_cnt", 32'(shed_cnt), 32'd2);
`endif

        // Skip a non-fitting high-priority port
        ports_off = 1;
        step();
        det = 4'b0011; pwr_req = 16'h444A;
        prio = 8'b00_00_00_11; pwr_bdj = 8'd8; ports_off = 0;
        repeat (12) step();
        chk("t3_on", 32'(on), 32'h2);
        chk("t3_used", 32'(pwr_used), 32'd4);

        // ports_off during ramp, then restart
        ports_off = 1;
        step();
        pwr_req = 16'h4444; pwr_bdj = 8'd100; det = 4'b1111; prio = '0;
        ports_off = 0;
        step();
        chk("t4_grant", 32'(on), 32'h1);
        step();
        ports_off = 1;
        step();
        chk("t4_off_on", 32'(on), 32'h0);
        chk("t4_off_busy", 32'(busy), 32'h0);
        ports_off = 0;
        step();
        chk("t4_regrant", 32'(grant), 32'h1);
        chk("t4_regrant_on", 32'(on), 32'h1);

        // Detection loss and forced-off
        det = 4'b1110;
        step();
        chk("t5_drop", 32'(on[0]), 32'h0);
        det = 4'b1111; off = 4'b0001;
        repeat (40) step();
        chk("t5_off", 32'(on), 32'hE);

        // Reset mid-ramp
        ports_off = 1;
        step();
        ports_off = 0; off = '0;
        step();
        repeat (3) step();
        rst_n = 0;
        step();
        chk("t6_on", 32'(on), 32'h0);
        chk("t6_gidx", 32'(grant_idx), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        rst_n = 1;
        step();
        chk("t6_regrant", 32'(grant), 32'h1);
        chk("t6_regrant_on", 32'(on), 32'h1);

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 9) == 0) det = 4'($urandom);
            if ($urandom_range(0, 19) == 0) off = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 14) == 0) prio = 8'($urandom);
            if ($urandom_range(0, 9) == 0) pwr_req = 16'($urandom);
            if ($urandom_range(0, 11) == 0) pwr_bdj = 8'($urandom_range(0, 60));
            ports_off = ($urandom_range(0, 59) == 0);
            rst_n = !($urandom_range(0, 149) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
